mod5_check_scheduler: RTL and testbench
=======================================

Name: mod5_check_scheduler

Overview:
- Shares one bit-serial divisibility-by-DIVISOR engine (default 5) among NREQ requesters, each presenting a DW-bit word.
- A round-robin arbiter grants one requester at a time and captures its word. A sequencer FSM shifts the word MSB-first through a remainder datapath.
- On completion the block emits a one-cycle result strobe tagged with the requester index.
- Sits between the requesting front-end units and the shared result consumer.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 6, data word width in bits (>=2)
- DIVISOR, 5, divisor tested (2..2**DW-1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  arbitration enable; 0 blocks new grants, an in-flight check still completes
- req  input  NREQ  per-requester request; must be held with stable data until granted
- din  input  NREQ*DW  packed words; requester i occupies bits [i*DW+DW-1 : i*DW]
- grant  output  NREQ  one-hot, one-cycle pulse; din of the granted requester is sampled in this cycle
- busy  output  1  high in SHIFT and DONE
- dout  output  1  1 = last checked word is a multiple of DIVISOR
- out_en  output  1  one-cycle result-valid strobe
- out_id  output  max(1,$clog2(NREQ))  index of the requester owning dout

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=IDLE, rr pointer=0 (requester 0 highest priority), remainder=0, shift reg=0.
  - Outputs: grant=0, busy=0, dout=0, out_en=0, out_id=0.
  - Reset has priority over all other inputs.
- FSM states:
  - IDLE: if en && |req, issue a grant; next state SHIFT, bit counter=0, remainder=0, shift reg=granted word. Otherwise stay in IDLE.
  - SHIFT: one bit per cycle, MSB first: rem_next = 2*rem + bit; if rem_next >= DIVISOR, subtract DIVISOR. Remainder register is $clog2(DIVISOR) bits; intermediate is one bit wider. After DW cycles, go to DONE.
  - DONE: out_en=1, dout=(rem==0), out_id=captured index. In the same cycle, if en && |req, grant again and go to SHIFT (back-to-back). Otherwise go to IDLE.
- Latency: grant at cycle T, SHIFT T+1..T+DW, out_en at T+DW+1. Back-to-back throughput is one check per DW+1 cycles.
- Arbitration:
  - Round-robin search starting at the rr pointer. After a grant to index k, rr pointer = (k+1) mod NREQ.
  - Only one grant per check; grant is never asserted in SHIFT.
  - A req dropped before its grant is silently not served.
  - A requester may reassert req the cycle after its grant; it is then considered in normal rotation.
- Output holding:
  - dout and out_id hold their value after out_en until the next DONE.
  - out_en is high for exactly one cycle per completed check.
- Capture: din changes after the grant cycle do not affect the in-flight check.
- en=0 during SHIFT/DONE: the current check finishes and reports normally; no grant in DONE, so the FSM returns to IDLE.
- Reset mid-SHIFT: the check is aborted, no out_en is issued for it, and the requester must re-request.
- Zero word: 0 is a multiple (dout=1).
- busy=1 exactly in SHIFT and DONE.

Test Plan:
- Single requester: req[0]=1, din word0=35, en=1 -> grant=0001 at T; out_en=1, dout=1, out_id=0 at T+7; busy high T+1..T+7.
- Value sweep on requester 2: words 0, 5, 60 -> dout=1; words 1, 63 (rem 3), 62 (rem 2) -> dout=0. Also cover the exhaustive 0..63 sweep against a `%5` model.
- Four requesters held high after reset: grants follow 0,1,2,3,0 at cycles T, T+7, T+14, T+21, T+28; out_id follows the same order; no idle gap between checks.
- Data capture: change din of the granted requester from 35 to 36 one cycle after grant -> result dout=1 (35 used).
- Reset mid-operation: rst=1 at T+3 of a check -> no out_en for it; all outputs 0; next grant goes to requester 0.
- Enable gating:
  - en=0 with req=1111 -> no grant indefinitely.
  - en dropped at T+2 of a check -> out_en still at T+7, then IDLE with no further grant until en=1.

Source files
------------

// File: rtl/mod5_check_scheduler_if.sv
// Requester/consumer bundle for the shared divisibility checker.
// master = front-end/consumer side, slave = the scheduler itself.
interface mod5_check_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 6
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                 en;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   din;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 dout;
    logic                 out_en;
    logic [IW-1:0]        out_id;

    modport master (
        output en, req, din,
        input  grant, busy, dout, out_en, out_id
    );

    modport slave (
        input  en, req, din,
        output grant, busy, dout, out_en, out_id
    );
endinterface

// File: rtl/mod5_check_scheduler.sv
// Shared bit-serial divisibility checker with a round-robin front end.
// One requester word is captured per grant and shifted MSB-first through
// a remainder datapath; the result is strobed out tagged with its owner.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for en && |req; grant and capture happen here
// SHIFT | one word bit per cycle into the remainder, DW cycles total
// DONE  | result strobe; may grant the next requester in the same cycle
module mod5_check_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 6,
    parameter int DIVISOR = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    mod5_check_scheduler_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam int CW = $clog2(DW);
    localparam logic [RW:0]   DIV_W  = (RW+1)'(DIVISOR);
    localparam logic [CW-1:0] LAST_B = CW'(DW - 1);
    localparam logic [IW-1:0] LAST_I = IW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   cap_idx_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   rem_q;
    logic [DW-1:0]   sreg_q;
    logic            dout_q;
    logic [IW-1:0]   id_q;

    logic            found;
    logic [IW-1:0]   win_idx;
    logic [DW-1:0]   word_sel;
    logic            grant_ok;
    logic [NREQ-1:0] grant_vec;
    logic [RW:0]     wide;
    logic [RW:0]     diff;
    logic [RW-1:0]   rem_nx;

    // Round-robin search: first requester at or after the pointer wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[(int'(ptr_q) + i) % NREQ]) begin
                found   = 1'b1;
                win_idx = IW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    // Pick the winner's word out of the packed din bus.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) word_sel = bus.din[i*DW +: DW];
        end
    end

    // Remainder step: shift in the next MSB and fold back below DIVISOR.
    always_comb begin
        wide   = {rem_q, sreg_q[DW-1]};
        diff   = wide - DIV_W;
        rem_nx = (wide >= DIV_W) ? diff[RW-1:0] : wide[RW-1:0];
    end

    // Next-state logic and grant decision; reset masks any grant.
    always_comb begin
        state_d   = state_q;
        grant_ok  = 1'b0;
        grant_vec = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.en && found) begin
                    grant_ok = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_B) state_d = DONE;
            end
            DONE: begin
                if (bus.en && found) begin
                    grant_ok = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) grant_ok = 1'b0;
        if (grant_ok) grant_vec[win_idx] = 1'b1;
    end

    // State, capture and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cap_idx_q <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            sreg_q    <= '0;
            dout_q    <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q <= state_d;
            if (grant_ok) begin
                sreg_q    <= word_sel;
                cap_idx_q <= win_idx;
                cnt_q     <= '0;
                rem_q     <= '0;
                ptr_q     <= (win_idx == LAST_I) ? '0 : win_idx + 1'b1;
            end else if (state_q == SHIFT) begin
                rem_q  <= rem_nx;
                sreg_q <= {sreg_q[DW-2:0], 1'b0};
                cnt_q  <= cnt_q + 1'b1;
                // Result registers load on the last bit so they are valid in
                // DONE and hold afterwards, even while the next word shifts.
                if (cnt_q == LAST_B) begin
                    dout_q <= (rem_nx == '0);
                    id_q   <= cap_idx_q;
                end
            end
        end
    end

    assign bus.grant  = grant_vec;
    assign bus.busy   = (state_q != IDLE);
    assign bus.out_en = (state_q == DONE);
    assign bus.dout   = dout_q;
    assign bus.out_id = id_q;
endmodule

// File: tb/tb_mod5_check_scheduler.sv
// Directed bench for mod5_check_scheduler: inputs change 1 time unit after
// the rising edge, outputs are sampled on the falling edge.
module tb_mod5_check_scheduler;
    localparam int NREQ    = 4;
    localparam int DW      = 6;
    localparam int DIVISOR = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mod5_check_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

    mod5_check_scheduler #(.NREQ(NREQ), .DW(DW), .DIVISOR(DIVISOR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        cyc();
        rst = 1'b1; bus.req = '0; bus.en = 1'b0; bus.din = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        rst = 1'b1; bus.req = 4'hF; bus.en = 1'b1; bus.din = '1;
        smp();
        n_checks++;
        if (bus.grant !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_grant_masked: got %b want 0000", bus.grant);
        end
        cyc();
        smp();
        n_checks++;
        if ({bus.grant, bus.busy, bus.dout, bus.out_en, bus.out_id} !== 9'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: grant=%b busy=%b dout=%b out_en=%b out_id=%0d want all 0",
                     bus.grant, bus.busy, bus.dout, bus.out_en, bus.out_id);
        end
        cyc();
        rst = 1'b0; bus.req = '0; bus.en = 1'b0; bus.din = '0;
    endtask

    // One isolated check on requester idx; din switches to 'after' right
    // after the grant, so the result must reflect 'word' only.
    task automatic do_single(input int idx, input logic [DW-1:0] word,
                             input logic [DW-1:0] after, input logic exp);
        logic [NREQ-1:0] eg;
        eg = '0;
        eg[idx] = 1'b1;
        bus.din[idx*DW +: DW] = word;
        bus.req = eg;
        bus.en  = 1'b1;
        smp();
        n_checks++;
        if (bus.grant !== eg) begin
            n_errors++;
            $display("FAIL single_grant w=%0d: got %b want %b", word, bus.grant, eg);
        end
        for (int k = 1; k <= DW + 1; k++) begin
            cyc();
            if (k == 1) begin
                bus.req = '0;
                bus.din[idx*DW +: DW] = after;
            end
            smp();
            n_checks++;
            if (bus.busy !== 1'b1 || bus.grant !== 4'b0000 || bus.out_en !== (k == DW + 1)) begin
                n_errors++;
                $display("FAIL single_cycle w=%0d k=%0d: busy=%b grant=%b out_en=%b want busy=1 grant=0000 out_en=%b",
                         word, k, bus.busy, bus.grant, bus.out_en, (k == DW + 1));
            end
            if (k == DW + 1) begin
                n_checks++;
                if (bus.dout !== exp || bus.out_id !== 2'(idx)) begin
                    n_errors++;
                    $display("FAIL single_result w=%0d: dout=%b out_id=%0d want dout=%b out_id=%0d",
                             word, bus.dout, bus.out_id, exp, idx);
                end
            end
        end
        cyc();
        smp();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.out_en !== 1'b0) begin
            n_errors++;
            $display("FAIL single_idle w=%0d: busy=%b out_en=%b want 0 0", word, bus.busy, bus.out_en);
        end
        cyc();
    endtask

    task automatic test_single();
        apply_reset();
        do_single(0, 6'd35, 6'd35, 1'b1);
    endtask

    task automatic test_values();
        apply_reset();
        do_single(2, 6'd0,  6'd0,  1'b1);
        do_single(2, 6'd5,  6'd5,  1'b1);
        do_single(2, 6'd60, 6'd60, 1'b1);
        do_single(2, 6'd1,  6'd1,  1'b0);
        do_single(2, 6'd63, 6'd63, 1'b0);
        do_single(2, 6'd62, 6'd62, 1'b0);
    endtask

    task automatic test_sweep();
        apply_reset();
        for (int w = 0; w < 64; w++) begin
            do_single(2, 6'(w), 6'(w + 1), ((w % DIVISOR) == 0));
        end
    endtask

    task automatic test_capture();
        apply_reset();
        do_single(0, 6'd35, 6'd36, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0]   w   [4];
        logic            ex  [4];
        logic [NREQ-1:0] eg;
        w  = '{6'd35, 6'd36, 6'd40, 6'd7};
        ex = '{1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < NREQ; i++) bus.din[i*DW +: DW] = w[i];
        bus.req = 4'hF;
        bus.en  = 1'b1;
        smp();
        n_checks++;
        if (bus.grant !== 4'b0001) begin
            n_errors++;
            $display("FAIL rr_first_grant: got %b want 0001", bus.grant);
        end
        for (int c = 0; c < 5; c++) begin
            for (int k = 1; k <= DW; k++) begin
                cyc();
                smp();
                n_checks++;
                if (bus.grant !== 4'b0000 || bus.busy !== 1'b1 || bus.out_en !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rr_shift c=%0d k=%0d: grant=%b busy=%b out_en=%b want 0000 1 0",
                             c, k, bus.grant, bus.busy, bus.out_en);
                end
            end
            cyc();
            smp();
            eg = '0;
            eg[(c + 1) % NREQ] = 1'b1;
            n_checks++;
            if (bus.out_en !== 1'b1 || bus.out_id !== 2'(c % NREQ) || bus.dout !== ex[c % NREQ]
                || bus.grant !== eg || bus.busy !== 1'b1) begin
                n_errors++;
                $display("FAIL rr_done c=%0d: out_en=%b out_id=%0d dout=%b grant=%b busy=%b want 1 %0d %b %b 1",
                         c, bus.out_en, bus.out_id, bus.dout, bus.grant, bus.busy,
                         c % NREQ, ex[c % NREQ], eg);
            end
        end
        cyc();
        bus.req = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_single(1, 6'd10, 6'd10, 1'b1);
        bus.din[2*DW +: DW] = 6'd5;
        bus.req = 4'b0100;
        bus.en  = 1'b1;
        smp();
        n_checks++;
        if (bus.grant !== 4'b0100) begin
            n_errors++;
            $display("FAIL mid_grant: got %b want 0100", bus.grant);
        end
        cyc();
        bus.req = '0;
        cyc();
        cyc();
        rst = 1'b1;
        smp();
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_busy_before_reset: got %b want 1", bus.busy);
        end
        cyc();
        rst = 1'b0;
        bus.req = 4'hF;
        smp();
        n_checks++;
        if ({bus.busy, bus.dout, bus.out_en, bus.out_id} !== 5'b0 || bus.grant !== 4'b0001) begin
            n_errors++;
            $display("FAIL mid_after_reset: busy=%b dout=%b out_en=%b out_id=%0d grant=%b want 0 0 0 0 0001",
                     bus.busy, bus.dout, bus.out_en, bus.out_id, bus.grant);
        end
        cyc();
        bus.req = '0;
        for (int k = 5; k <= 10; k++) begin
            smp();
            n_checks++;
            if (bus.out_en !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_no_strobe T+%0d: out_en=%b want 0", k, bus.out_en);
            end
            cyc();
        end
        smp();
        n_checks++;
        if (bus.out_en !== 1'b1 || bus.dout !== 1'b1 || bus.out_id !== 2'd0) begin
            n_errors++;
            $display("FAIL mid_next_result: out_en=%b dout=%b out_id=%0d want 1 1 0",
                     bus.out_en, bus.dout, bus.out_id);
        end
        cyc();
    endtask

    task automatic test_enable();
        apply_reset();
        bus.din[0 +: DW] = 6'd10;
        bus.req = 4'hF;
        bus.en  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            smp();
            n_checks++;
            if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
                n_errors++;
                $display("FAIL en_low_no_grant k=%0d: grant=%b busy=%b want 0000 0", k, bus.grant, bus.busy);
            end
            cyc();
        end
        bus.en = 1'b1;
        smp();
        n_checks++;
        if (bus.grant !== 4'b0001) begin
            n_errors++;
            $display("FAIL en_grant: got %b want 0001", bus.grant);
        end
        cyc();
        cyc();
        bus.en = 1'b0;
        for (int k = 2; k <= DW + 1; k++) begin
            smp();
            n_checks++;
            if (bus.busy !== 1'b1 || bus.grant !== 4'b0000 || bus.out_en !== (k == DW + 1)) begin
                n_errors++;
                $display("FAIL en_drop_cycle T+%0d: busy=%b grant=%b out_en=%b want 1 0000 %b",
                         k, bus.busy, bus.grant, bus.out_en, (k == DW + 1));
            end
            if (k == DW + 1) begin
                n_checks++;
                if (bus.dout !== 1'b1 || bus.out_id !== 2'd0) begin
                    n_errors++;
                    $display("FAIL en_drop_result: dout=%b out_id=%0d want 1 0", bus.dout, bus.out_id);
                end
            end
            cyc();
        end
        for (int k = 0; k < 5; k++) begin
            smp();
            n_checks++;
            if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.out_en !== 1'b0) begin
                n_errors++;
                $display("FAIL en_drop_idle k=%0d: busy=%b grant=%b out_en=%b want 0 0000 0",
                         k, bus.busy, bus.grant, bus.out_en);
            end
            cyc();
        end
        bus.en = 1'b1;
        smp();
        n_checks++;
        if (bus.grant !== 4'b0010) begin
            n_errors++;
            $display("FAIL en_resume_grant: got %b want 0010", bus.grant);
        end
        cyc();
        bus.en  = 1'b0;
        bus.req = '0;
    endtask

    initial begin
        bus.req = '0;
        bus.en  = 1'b0;
        bus.din = '0;
        test_reset();
        test_single();
        test_values();
        test_capture();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
